// File: rtl/uart_tx_engine_if.sv
// ---------------------------------------------------------------------------
// uart_tx_engine_if
// Handshake/data bundle between the TX-side data synchroniser (master) and
// the UART transmit engine (slave).
//   P_DATA      word to send, sampled on acceptance
//   Data_Valid  request to send P_DATA
//   Parity_EN   append parity bit (sampled on acceptance)
//   Parity_Type 0 = even, 1 = odd (sampled on acceptance)
//   Stop2_EN    two stop bits (sampled on acceptance)
//   TX_OUT      serial line, idles high
//   busy        a frame occupies the line
//   tx_ack      pulse in the cycle a request is accepted
//   excep       pulse when acceptance is back-to-back with the previous frame
// ---------------------------------------------------------------------------
interface uart_tx_engine_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  Parity_EN;
    logic                  Parity_Type;
    logic                  Stop2_EN;
    logic                  TX_OUT;
    logic                  busy;
    logic                  tx_ack;
    logic                  excep;

    modport master (
        output P_DATA, Data_Valid, Parity_EN, Parity_Type, Stop2_EN,
        input  TX_OUT, busy, tx_ack, excep
    );

    modport slave (
        input  P_DATA, Data_Valid, Parity_EN, Parity_Type, Stop2_EN,
        output TX_OUT, busy, tx_ack, excep
    );
endinterface

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// UART transmit engine: serialises one DATA_WIDTH-bit word per frame, LSB
// first, with optional even/odd parity and one or two stop bits. CLK is the
// baud clock (one line bit per cycle).
//   CLK   baud clock, rising edge
//   RST   asynchronous, active-low reset
//   bus   uart_tx_engine_if.slave (data/config in, TX_OUT/busy/tx_ack/excep out)
// ---------------------------------------------------------------------------
module uart_tx_engine #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic               CLK,
    input  logic               RST,
    uart_tx_engine_if.slave    bus
);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP1  = 3'd4,
        STOP2  = 3'd5
    } state_t;

    state_t                state_q, state_n;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  par_en_q;
    logic                  par_bit_q;
    logic                  stop2_q;
    logic                  final_stop;
    logic                  accept;
    logic                  tx_n;

    always_comb begin
        final_stop = (state_q == STOP2) || ((state_q == STOP1) && !stop2_q);
        accept     = bus.Data_Valid && ((state_q == IDLE) || final_stop);
    end

    // Acknowledge/exception are combinational on the accepting cycle; gated
    // by RST so nothing is signalled while the block is held in reset.
    assign bus.tx_ack = accept && RST;
    assign bus.excep  = accept && final_stop && RST;

    always_comb begin
        state_n = state_q;
        case (state_q)
            IDLE:    state_n = accept ? START : IDLE;
            START:   state_n = DATA;
            DATA: begin
                if (cnt_q == CNT_W'(DATA_WIDTH - 1))
                    state_n = par_en_q ? PARITY : STOP1;
            end
            PARITY:  state_n = STOP1;
            STOP1: begin
                if (stop2_q)     state_n = STOP2;
                else if (accept) state_n = START;
                else             state_n = IDLE;
            end
            STOP2:   state_n = accept ? START : IDLE;
            default: state_n = IDLE;
        endcase

        // TX_OUT is registered from the next state so the line changes on
        // the same edge as the state it represents.
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_q[0];
            PARITY:  tx_n = par_bit_q;
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            bus.TX_OUT <= 1'b1;
            bus.busy   <= 1'b0;
            shift_q    <= '0;
            cnt_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            stop2_q    <= 1'b0;
        end else begin
            state_q    <= state_n;
            bus.TX_OUT <= tx_n;
            bus.busy   <= (state_n != IDLE);
            cnt_q      <= (state_q == DATA) ? cnt_q + 1'b1 : '0;

            // Parity is resolved at acceptance from the latched word and
            // type, so only the resulting line bit needs to be held.
            if (accept) begin
                shift_q   <= bus.P_DATA;
                par_en_q  <= bus.Parity_EN;
                par_bit_q <= (^bus.P_DATA) ^ bus.Parity_Type;
                stop2_q   <= bus.Stop2_EN;
            end else if (state_n == DATA) begin
                shift_q   <= shift_q >> 1;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
module tb_uart_tx_engine;
    logic CLK = 1'b0;
    logic RST = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    uart_tx_engine_if #(.DATA_WIDTH(8)) bus8 ();
    uart_tx_engine_if #(.DATA_WIDTH(5)) bus5 ();

    uart_tx_engine #(.DATA_WIDTH(8)) dut8 (.CLK(CLK), .RST(RST), .bus(bus8));
    uart_tx_engine #(.DATA_WIDTH(5)) dut5 (.CLK(CLK), .RST(RST), .bus(bus5));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic load8(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
        bus8.P_DATA      = d;
        bus8.Parity_EN   = pe;
        bus8.Parity_Type = pt;
        bus8.Stop2_EN    = s2;
        bus8.Data_Valid  = 1'b1;
        #1;
    endtask

    // Called at an idle point with a request already presented. After the
    // accepting edge every config input is inverted to prove it was latched;
    // poke >= 0 re-asserts Data_Valid in that frame cycle (must be ignored).
    task automatic frame8(input string tag, input string pat, input int poke);
        chk($sformatf("%s_ack", tag), bus8.tx_ack, 1'b1);
        chk($sformatf("%s_exc0", tag), bus8.excep, 1'b0);
        chk($sformatf("%s_busy0", tag), bus8.busy, 1'b0);
        @(negedge CLK);
        bus8.P_DATA      = ~bus8.P_DATA;
        bus8.Parity_EN   = ~bus8.Parity_EN;
        bus8.Parity_Type = ~bus8.Parity_Type;
        bus8.Stop2_EN    = ~bus8.Stop2_EN;
        for (int i = 0; i < pat.len(); i++) begin
            bus8.Data_Valid = (i == poke);
            #1;
            chk($sformatf("%s_tx%0d", tag, i), bus8.TX_OUT, pat[i] == 8'h31);
            chk($sformatf("%s_busy%0d", tag, i), bus8.busy, 1'b1);
            chk($sformatf("%s_noack%0d", tag, i), bus8.tx_ack, 1'b0);
            chk($sformatf("%s_noexc%0d", tag, i), bus8.excep, 1'b0);
            @(negedge CLK);
        end
        bus8.Data_Valid = 1'b0;
        #1;
        chk($sformatf("%s_end_busy", tag), bus8.busy, 1'b0);
        chk($sformatf("%s_end_tx", tag), bus8.TX_OUT, 1'b1);
    endtask

    initial begin
        string p1;
        string p2;
        string p5;

        bus8.P_DATA = '0; bus8.Data_Valid = 1'b0; bus8.Parity_EN = 1'b0;
        bus8.Parity_Type = 1'b0; bus8.Stop2_EN = 1'b0;
        bus5.P_DATA = '0; bus5.Data_Valid = 1'b0; bus5.Parity_EN = 1'b0;
        bus5.Parity_Type = 1'b0; bus5.Stop2_EN = 1'b0;

        // Reset state
        repeat (2) @(negedge CLK);
        chk("rst_tx8", bus8.TX_OUT, 1'b1);
        chk("rst_busy8", bus8.busy, 1'b0);
        chk("rst_ack8", bus8.tx_ack, 1'b0);
        chk("rst_exc8", bus8.excep, 1'b0);
        chk("rst_tx5", bus5.TX_OUT, 1'b1);
        chk("rst_busy5", bus5.busy, 1'b0);
        RST = 1'b1;
        @(negedge CLK);

        // A5 even parity, one stop
        load8(8'hA5, 1'b1, 1'b0, 1'b0);
        frame8("even", "01010010101", -1);
        // A5 odd parity
        load8(8'hA5, 1'b1, 1'b1, 1'b0);
        frame8("odd", "01010010111", -1);
        // A5 no parity, two stops
        load8(8'hA5, 1'b0, 1'b0, 1'b1);
        frame8("nopar_s2", "01010010111", -1);
        // 80 even parity, two stops: 12 cycles
        load8(8'h80, 1'b1, 1'b0, 1'b1);
        frame8("par_s2", "000000001111", -1);
        // Inputs change mid-frame and a request arrives during DATA bit 3
        load8(8'hA5, 1'b1, 1'b0, 1'b0);
        frame8("midchg", "01010010101", 4);

        // Back-to-back: Data_Valid held, 00 then FF, no parity, one stop
        p1 = "0000000001";
        p2 = "0111111111";
        load8(8'h00, 1'b0, 1'b0, 1'b0);
        chk("b2b_ack0", bus8.tx_ack, 1'b1);
        chk("b2b_exc0", bus8.excep, 1'b0);
        @(negedge CLK);
        bus8.P_DATA = 8'hFF;
        for (int i = 0; i < p1.len(); i++) begin
            #1;
            chk($sformatf("b2b_a_tx%0d", i), bus8.TX_OUT, p1[i] == 8'h31);
            chk($sformatf("b2b_a_busy%0d", i), bus8.busy, 1'b1);
            chk($sformatf("b2b_a_ack%0d", i), bus8.tx_ack, i == 9);
            chk($sformatf("b2b_a_exc%0d", i), bus8.excep, i == 9);
            @(negedge CLK);
        end
        bus8.Data_Valid = 1'b0;
        bus8.P_DATA     = 8'h00;
        for (int i = 0; i < p2.len(); i++) begin
            #1;
            chk($sformatf("b2b_b_tx%0d", i), bus8.TX_OUT, p2[i] == 8'h31);
            chk($sformatf("b2b_b_busy%0d", i), bus8.busy, 1'b1);
            chk($sformatf("b2b_b_exc%0d", i), bus8.excep, 1'b0);
            @(negedge CLK);
        end
        #1;
        chk("b2b_end_busy", bus8.busy, 1'b0);

        // Reset during DATA bit 3
        load8(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("mrst_ack", bus8.tx_ack, 1'b1);
        @(negedge CLK);
        bus8.Data_Valid = 1'b0;
        repeat (4) @(negedge CLK);
        #1;
        chk("mrst_pre_tx", bus8.TX_OUT, 1'b0);
        chk("mrst_pre_busy", bus8.busy, 1'b1);
        RST = 1'b0;
        #1;
        chk("mrst_tx", bus8.TX_OUT, 1'b1);
        chk("mrst_busy", bus8.busy, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        #1;
        chk("mrst_idle_tx", bus8.TX_OUT, 1'b1);
        chk("mrst_idle_busy", bus8.busy, 1'b0);
        // 3C odd parity after reset
        load8(8'h3C, 1'b1, 1'b1, 1'b0);
        frame8("after_rst", "00011110011", -1);

        // DATA_WIDTH=5, 13 even parity
        p5 = "01100111";
        bus5.P_DATA      = 5'h13;
        bus5.Parity_EN   = 1'b1;
        bus5.Parity_Type = 1'b0;
        bus5.Stop2_EN    = 1'b0;
        bus5.Data_Valid  = 1'b1;
        #1;
        chk("w5_ack", bus5.tx_ack, 1'b1);
        @(negedge CLK);
        bus5.Data_Valid = 1'b0;
        bus5.P_DATA     = 5'h0C;
        for (int i = 0; i < p5.len(); i++) begin
            #1;
            chk($sformatf("w5_tx%0d", i), bus5.TX_OUT, p5[i] == 8'h31);
            chk($sformatf("w5_busy%0d", i), bus5.busy, 1'b1);
            @(negedge CLK);
        end
        #1;
        chk("w5_end_busy", bus5.busy, 1'b0);
        chk("w5_end_tx", bus5.TX_OUT, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
